// File: rtl/dacx311_pkg.sv
// Shared DACx311 frame definition: field positions, frame length and receiver states.
// Used by both the transmit-side dacx311 and the receive-side dacx311_rx.
package dacx311_pkg;

    localparam int FRAME_BITS = 16;
    localparam int PD_MSB     = 15;
    localparam int PD_LSB     = 14;
    localparam int DATA_MSB   = 13;
    localparam int DATA_LSB   = 2;
    localparam int CNT_W      = 5;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/dacx311_rx_sync_edge.sv
// Input conditioner: optional 2-flop synchroniser (DACX311_RX_SYNC_EN) followed by a
// level register and a delay register, giving the level plus rising/falling pulses.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic din_s;
    logic q;
    logic d;

`ifdef DACX311_RX_SYNC_EN
    logic [1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) meta <= {din, din};
        else       meta <= {meta[0], din};
    end

    assign din_s = meta[1];
`else
    assign din_s = din;
`endif

    // NOTE: under reset every stage loads the live pin level instead of a constant, so a
    // line already high at reset release does not look like a fresh rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= din;
            d <= din;
        end else begin
            q <= din_s;
            d <= q;
        end
    end

    assign level = q;
    assign rise  = q & ~d;
    assign fall  = ~q & d;

endmodule

// File: rtl/dacx311_rx.sv
// DACx311 SPI responder: deserialises 16-bit {pd, data, xx} frames into the clk domain.
// Define DACX311_RX_SYNC_EN to put 2-flop synchronisers on sclk/ss/mosi (adds 2 cycles latency).
module dacx311_rx
    import dacx311_pkg::*;
#(
    parameter logic [11:0] DATA_INIT = 12'h000,
    parameter logic [1:0]  PD_INIT   = 2'b00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        ss,
    input  logic        mosi,
    output logic [1:0]  pd,
    output logic [11:0] data,
    output logic        valid,
    output logic        err,
    output logic        busy
);

    logic sclk_level_unused;
    logic sclk_rise_unused;
    logic sclk_fall;
    logic ss_level;
    logic ss_rise;
    logic ss_fall;

    sync_edge u_sclk (
        .clk   (clk),
        .reset (reset),
        .din   (sclk),
        .level (sclk_level_unused),
        .rise  (sclk_rise_unused),
        .fall  (sclk_fall)
    );

    sync_edge u_ss (
        .clk   (clk),
        .reset (reset),
        .din   (ss),
        .level (ss_level),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    // mosi goes through the same pipeline depth as sclk/ss so it is aligned at the edge pulse.
    logic mosi_s;
    logic mosi_q;

`ifdef DACX311_RX_SYNC_EN
    logic [1:0] mosi_meta;

    always_ff @(posedge clk) begin
        mosi_meta <= {mosi_meta[0], mosi};
    end

    assign mosi_s = mosi_meta[1];
`else
    assign mosi_s = mosi;
`endif

    // NOTE: pure data-path flop, never reset; its value is only consumed on a qualified edge.
    always_ff @(posedge clk) begin
        mosi_q <= mosi_s;
    end

    state_t                  state;
    logic [CNT_W-1:0]        cnt;
    logic [FRAME_BITS-2:0]   shreg;     // top bit is never stored: the 16th bit comes straight from mosi_q
    logic                    overrun;
    logic [FRAME_BITS-1:0]   shifted;
    logic                    sclk_ok;
    logic                    last_bit;

    assign shifted  = {shreg, mosi_q};
    // An sclk edge coinciding with the ss falling edge still belongs to the frame.
    assign sclk_ok  = sclk_fall & (ss_level | ss_fall);
    assign last_bit = (cnt == CNT_W'(FRAME_BITS - 1));

    // NOTE: all state updates use non-blocking assignments; later assignments in the same
    // cycle deliberately override earlier ones (ss falling edge is processed after sclk).
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            overrun <= 1'b0;
            pd      <= PD_INIT;
            data    <= DATA_INIT;
            valid   <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_rise) begin
                        cnt   <= '0;
                        shreg <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (sclk_ok) begin
                        shreg <= shifted[FRAME_BITS-2:0];
                        cnt   <= cnt + 1'b1;
                        if (last_bit) begin
                            pd    <= shifted[PD_MSB:PD_LSB];
                            data  <= shifted[DATA_MSB:DATA_LSB];
                            valid <= 1'b1;
                            state <= DONE;
                        end
                    end
                    if (ss_fall) begin
                        err   <= ~(sclk_ok & last_bit);
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                DONE: begin
                    if (sclk_ok) overrun <= 1'b1;
                    if (ss_fall) begin
                        err     <= overrun | sclk_ok;
                        overrun <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dacx311_rx.sv
// Self-checking bench for dacx311_rx: direct SPI drive, expected valid/err events kept in a
// scoreboard queue with their expected cycle, popped as the DUT pulses its outputs.
module tb_dacx311_rx;

    localparam logic [11:0] DATA_INIT = 12'h5a3;
    localparam logic [1:0]  PD_INIT   = 2'b01;
`ifdef DACX311_RX_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        bit          is_err;
        logic [1:0]  pd;
        logic [11:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        ss;
    logic        mosi;
    logic [1:0]  pd;
    logic [11:0] data;
    logic        valid;
    logic        err;
    logic        busy;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [1:0]  model_pd = PD_INIT;
    logic [11:0] model_data = DATA_INIT;

    dacx311_rx #(
        .DATA_INIT (DATA_INIT),
        .PD_INIT   (PD_INIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sclk  (sclk),
        .ss    (ss),
        .mosi  (mosi),
        .pd    (pd),
        .data  (data),
        .valid (valid),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Advance one cycle; on the falling clk edge compare any valid/err pulse with the scoreboard.
    task automatic step();
        exp_t e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (valid || err) begin
            checks++;
            if (valid && err) begin
                errors++;
                $display("FAIL valid_err_overlap cyc=%0d: both high, required at most one", cyc);
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event cyc=%0d: got valid=%b err=%b pd=%b data=%h, required none",
                         cyc, valid, err, pd, data);
            end else begin
                e = exp_q.pop_front();
                if (e.is_err !== err || e.cyc != cyc ||
                    (valid && (pd !== e.pd || data !== e.data))) begin
                    errors++;
                    $display("FAIL scoreboard cyc=%0d: got err=%b pd=%b data=%h, required err=%b pd=%b data=%h at cyc=%0d",
                             cyc, err, pd, data, e.is_err, e.pd, e.data, e.cyc);
                end
            end
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_event: %0d expected events not seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy: got %b, required 0", name, busy);
        end
        checks++;
        if (pd !== model_pd || data !== model_data) begin
            errors++;
            $display("FAIL %s_outputs: got pd=%b data=%h, required pd=%b data=%h",
                     name, pd, data, model_pd, model_data);
        end
    endtask

    // Drive one frame of nedges sclk pulses. rst_after>0 pulses reset after that many edges.
    // same_cycle drops ss on the same clk as the last sclk falling edge.
    task automatic send_frame(input string name, input logic [15:0] word, input int nedges,
                              input int rst_after, input bit same_cycle);
        exp_t e;
        bit   aborted;
        bit   last;
        aborted = 1'b0;
        ss = 1'b1;
        repeat (3) step();
        for (int i = 0; i < nedges; i++) begin
            mosi = (i < 16) ? word[15-i] : 1'b1;
            sclk = 1'b1;
            repeat (3) step();
            if (i == 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s_busy_in_frame: got %b, required 1", name, busy);
                end
            end
            last = (i == nedges - 1);
            sclk = 1'b0;
            if (last && same_cycle) ss = 1'b0;
            if (!aborted && i == 15) begin
                e = '{1'b0, word[15:14], word[13:2], cyc + LAT};
                exp_q.push_back(e);
                model_pd   = word[15:14];
                model_data = word[13:2];
            end
            if (!aborted && last && same_cycle && nedges != 16) begin
                e = '{1'b1, 2'b00, 12'h000, cyc + LAT};
                exp_q.push_back(e);
            end
            repeat (3) step();
            if (rst_after == i + 1) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                aborted = 1'b1;
                model_pd   = PD_INIT;
                model_data = DATA_INIT;
                checks++;
                if (pd !== PD_INIT || data !== DATA_INIT || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_after_reset: got pd=%b data=%h busy=%b, required pd=%b data=%h busy=0",
                             name, pd, data, busy, PD_INIT, DATA_INIT);
                end
                step();
            end
        end
        if (!same_cycle) begin
            ss = 1'b0;
            if (!aborted && nedges != 16) begin
                e = '{1'b1, 2'b00, 12'h000, cyc + LAT};
                exp_q.push_back(e);
            end
        end
        repeat (8) step();
        check_idle(name);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sclk  = 1'b0;
        ss    = 1'b0;
        mosi  = 1'b0;
        repeat (3) step();
        checks++;
        if (pd !== PD_INIT || data !== DATA_INIT) begin
            errors++;
            $display("FAIL reset_outputs: got pd=%b data=%h, required pd=%b data=%h",
                     pd, data, PD_INIT, DATA_INIT);
        end
        checks++;
        if (valid !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b err=%b busy=%b, required 0 0 0", valid, err, busy);
        end
        reset = 1'b0;
        repeat (3) step();
        check_idle("reset_release");
    endtask

    task automatic test_frames();
        send_frame("frame_3ffc", 16'h3ffc, 16, 0, 1'b0);
        send_frame("frame_048c", 16'h048c, 16, 0, 1'b0);
        send_frame("frame_c000", 16'hc000, 16, 0, 1'b0);
        send_frame("frame_3ffd", 16'h3ffd, 16, 0, 1'b0);
    endtask

    task automatic test_short_frame();
        send_frame("short_10", 16'h9876, 10, 0, 1'b0);
    endtask

    task automatic test_overrun();
        send_frame("overrun_17", 16'h5a5a, 17, 0, 1'b0);
    endtask

    task automatic test_same_cycle();
        send_frame("same_cycle_16", 16'h8abc, 16, 0, 1'b1);
        send_frame("same_cycle_17", 16'h4321, 17, 0, 1'b1);
        send_frame("same_cycle_12", 16'h1111, 12, 0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        send_frame("reset_mid", 16'h6789, 16, 8, 1'b0);
        send_frame("after_reset", 16'hb2c8, 16, 0, 1'b0);
    endtask

    task automatic test_ss_high_at_reset();
        ss = 1'b1;
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        model_pd   = PD_INIT;
        model_data = DATA_INIT;
        repeat (3) step();
        for (int i = 0; i < 16; i++) begin
            mosi = 1'b1;
            sclk = 1'b1;
            repeat (3) step();
            sclk = 1'b0;
            repeat (3) step();
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL ss_high_reset_busy: got %b, required 0", busy);
        end
        ss = 1'b0;
        repeat (8) step();
        check_idle("ss_high_reset");
    endtask

    task automatic test_back_to_back();
        logic [15:0] w;
        for (int k = 0; k < 6; k++) begin
            w = 16'($urandom);
            send_frame("back_to_back", w, 16, 0, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_short_frame();
        test_overrun();
        test_same_cycle();
        test_reset_mid_frame();
        test_ss_high_at_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
